// File: rtl/i2s_codec_bridge_pkg.sv
// Shared defaults, slot encoding and parameter helpers for the I2S codec bridge.
// Imported by the clock generator and the bridge top.
package i2s_codec_bridge_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_SLOT_WIDTH = 32;
    localparam int DEFAULT_BCLK_DIV   = 4;

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } slot_t;

    // Counter width that never collapses to zero bits for a divide-by-one.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit params_legal(input int dw, input int sw, input int div);
        return (dw >= 2) && (dw <= sw - 1) && (div >= 1);
    endfunction

endpackage

// File: rtl/i2s_clock_gen.sv
// Master-mode I2S timing: divides clk into bclk, tracks the frame bit counter
// and produces registered rise/fall strobes aligned with the bclk edges.
module i2s_clock_gen
    import i2s_codec_bridge_pkg::*;
#(
    parameter int bclk_div   = DEFAULT_BCLK_DIV,
    parameter int slot_width = DEFAULT_SLOT_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset,
    output logic                            bclk,
    output logic                            lrclk,
    output logic                            rise,
    output logic                            fall,
    output logic [$clog2(2*slot_width)-1:0] k
);

    localparam int FRAME_LEN = 2 * slot_width;
    localparam int K_W       = $clog2(FRAME_LEN);
    localparam int DIV_W     = width_of(bclk_div);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(bclk_div - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(FRAME_LEN - 1);
    localparam logic [K_W-1:0]   SLOT_K   = K_W'(slot_width);

    logic [DIV_W-1:0] div_reg;
    logic [K_W-1:0]   k_reg;
    logic [K_W-1:0]   k_next;
    logic             bclk_reg;
    logic             lrclk_reg;
    logic             rise_reg;
    logic             fall_reg;
    logic             started_reg;

    // The very first falling edge after reset opens period 0 rather than advancing.
    always_comb begin
        k_next = k_reg + K_W'(1);
        if (!started_reg || (k_reg == K_LAST)) begin
            k_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg     <= '0;
            k_reg       <= '0;
            bclk_reg    <= 1'b0;
            lrclk_reg   <= 1'b0;
            rise_reg    <= 1'b0;
            fall_reg    <= 1'b0;
            started_reg <= 1'b0;
        end else begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            if (div_reg == DIV_LAST) begin
                div_reg  <= '0;
                bclk_reg <= !bclk_reg;
                if (bclk_reg) begin
                    fall_reg    <= 1'b1;
                    started_reg <= 1'b1;
                    k_reg       <= k_next;
                    lrclk_reg   <= (k_next >= SLOT_K);
                end else begin
                    rise_reg <= 1'b1;
                end
            end else begin
                div_reg <= div_reg + DIV_W'(1);
            end
        end
    end

    assign bclk  = bclk_reg;
    assign lrclk = lrclk_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;
    assign k     = k_reg;

endmodule

// File: rtl/i2s_codec_bridge.sv
// I2S master bridge between the audio codec and the DSP engine: left-channel
// ADC deserialiser, engine output capture, DAC serialiser and overrun/underrun flags.
module i2s_codec_bridge
    import i2s_codec_bridge_pkg::*;
#(
    parameter int data_width = DEFAULT_DATA_WIDTH,
    parameter int slot_width = DEFAULT_SLOT_WIDTH,
    parameter int bclk_div   = DEFAULT_BCLK_DIV
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  bclk,
    output logic                  lrclk,
    input  logic                  adc_data,
    output logic                  dac_data,
    output logic [data_width-1:0] in_sample,
    output logic                  sample_valid,
    input  logic [data_width-1:0] out_sample,
    input  logic                  out_ready,
    output logic                  rx_overrun,
    output logic                  tx_underrun
);

    localparam int K_W = $clog2(2 * slot_width);
    localparam logic [K_W-1:0] SLOT_K = K_W'(slot_width);
    localparam logic [K_W-1:0] DATA_K = K_W'(data_width);

    if (!params_legal(data_width, slot_width, bclk_div)) begin : g_bad_params
        $error("i2s_codec_bridge: need 2 <= data_width <= slot_width-1 and bclk_div >= 1");
    end

    logic           rise;
    logic           fall;
    logic [K_W-1:0] k;
    logic [K_W-1:0] p;

    i2s_clock_gen #(
        .bclk_div   (bclk_div),
        .slot_width (slot_width)
    ) u_clock_gen (
        .clk   (clk),
        .reset (reset),
        .bclk  (bclk),
        .lrclk (lrclk),
        .rise  (rise),
        .fall  (fall),
        .k     (k)
    );

    assign p = (k >= SLOT_K) ? (k - SLOT_K) : k;

    logic rx_bit;
    logic rx_last;
    logic tx_bit;
    logic frame_start;
    logic capture;

    assign rx_bit      = rise && (lrclk == SLOT_LEFT) && (p != '0) && (p <= DATA_K);
    assign rx_last     = rx_bit && (p == DATA_K);
    assign tx_bit      = fall && (p != '0) && (p <= DATA_K);
    assign frame_start = fall && (k == '0);

    logic [data_width-1:0] rx_shift_reg;
    logic [data_width-1:0] rx_shift_next;
    logic [data_width-1:0] in_sample_reg;
    logic                  sample_valid_reg;
    logic                  rx_overrun_reg;
    logic [data_width-1:0] hold_reg;
    logic                  fresh_reg;
    logic                  ready_prev_reg;
    logic [data_width-1:0] tx_shift_reg;
    logic [data_width-1:0] tx_rot_next;
    logic                  dac_data_reg;
    logic                  tx_underrun_reg;

    assign capture       = out_ready && !ready_prev_reg;
    assign rx_shift_next = {rx_shift_reg[data_width-2:0], adc_data};

    // Rotate rather than shift so the same word comes back out for the right slot.
    for (genvar gi = 0; gi < data_width; gi++) begin : g_tx_rot
        assign tx_rot_next[gi] = tx_shift_reg[(gi + data_width - 1) % data_width];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_shift_reg     <= '0;
            in_sample_reg    <= '0;
            sample_valid_reg <= 1'b0;
            rx_overrun_reg   <= 1'b0;
            hold_reg         <= '0;
            fresh_reg        <= 1'b0;
            ready_prev_reg   <= 1'b1;
            tx_shift_reg     <= '0;
            dac_data_reg     <= 1'b0;
            tx_underrun_reg  <= 1'b0;
        end else begin
            ready_prev_reg   <= out_ready;
            sample_valid_reg <= 1'b0;
            rx_overrun_reg   <= 1'b0;
            tx_underrun_reg  <= 1'b0;

            if (rx_bit) begin
                rx_shift_reg <= rx_shift_next;
            end
            if (rx_last) begin
                in_sample_reg    <= rx_shift_next;
                sample_valid_reg <= 1'b1;
                rx_overrun_reg   <= !out_ready;
            end

            if (capture) begin
                hold_reg <= out_sample;
            end

            // A capture landing on the frame boundary is kept fresh for the following frame.
            if (frame_start) begin
                tx_shift_reg    <= hold_reg;
                tx_underrun_reg <= !fresh_reg;
                fresh_reg       <= capture;
            end else begin
                if (capture) begin
                    fresh_reg <= 1'b1;
                end
                if (tx_bit) begin
                    tx_shift_reg <= tx_rot_next;
                end
            end

            if (fall) begin
                dac_data_reg <= tx_bit ? tx_shift_reg[data_width-1] : 1'b0;
            end
        end
    end

    assign in_sample    = in_sample_reg;
    assign sample_valid = sample_valid_reg;
    assign rx_overrun   = rx_overrun_reg;
    assign dac_data     = dac_data_reg;
    assign tx_underrun  = tx_underrun_reg;

endmodule

// File: tb/tb_i2s_codec_bridge.sv
// Bench for i2s_codec_bridge: a cycle-indexed model of the I2S frame derived from
// the frame arithmetic, checked against every output on every clock.
module tb_i2s_codec_bridge;

    localparam int DW  = 16;
    localparam int SW  = 32;
    localparam int DIV = 2;
    localparam int FRAME_CLK = 4 * DIV * SW;

    logic          clk;
    logic          reset;
    logic          bclk;
    logic          lrclk;
    logic          adc_data;
    logic          dac_data;
    logic [DW-1:0] in_sample;
    logic          sample_valid;
    logic [DW-1:0] out_sample;
    logic          out_ready;
    logic          rx_overrun;
    logic          tx_underrun;

    i2s_codec_bridge #(
        .data_width (DW),
        .slot_width (SW),
        .bclk_div   (DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .adc_data     (adc_data),
        .dac_data     (dac_data),
        .in_sample    (in_sample),
        .sample_valid (sample_valid),
        .out_sample   (out_sample),
        .out_ready    (out_ready),
        .rx_overrun   (rx_overrun),
        .tx_underrun  (tx_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int valid_seen = 0;

    // Reference state: n counts clock edges since the last edge that saw reset.
    int          n = 0;
    logic [15:0] left_w  [0:15];
    logic [15:0] right_w [0:15];
    logic [15:0] hold_m = '0;
    logic [15:0] tx_m   = '0;
    logic [15:0] in_m   = '0;
    bit          fresh_m = 1'b0;
    bit          rprev_m = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    // One clock: update the model with the inputs present at the edge, compare
    // every output, then present the ADC bit for the current bit period.
    task automatic tick();
        bit exp_valid;
        bit exp_ovr;
        bit exp_und;
        bit exp_bclk;
        bit exp_lr;
        bit exp_dac;
        bit cap;
        int kd;
        int pd;
        int kk;
        int ff;
        @(negedge clk);
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
        exp_und   = 1'b0;
        if (reset) begin
            n       = 0;
            hold_m  = '0;
            tx_m    = '0;
            in_m    = '0;
            fresh_m = 1'b0;
            rprev_m = 1'b1;
        end else begin
            n++;
            cap     = out_ready && !rprev_m;
            rprev_m = out_ready;
            if (n >= 5 && (n - 5) % FRAME_CLK == 0) begin
                tx_m    = hold_m;
                exp_und = !fresh_m;
                fresh_m = cap;
            end else if (cap) begin
                fresh_m = 1'b1;
            end
            if (cap) hold_m = out_sample;
            if (n >= 71 && (n - 71) % FRAME_CLK == 0) begin
                in_m      = left_w[((n - 71) / FRAME_CLK) & 15];
                exp_valid = 1'b1;
                exp_ovr   = !out_ready;
            end
        end
        exp_bclk = ((n / DIV) % 2) == 1;
        exp_lr   = (n >= 4) && (((n / 4 - 1) % 64) >= SW);
        exp_dac  = 1'b0;
        if (n >= 5) begin
            kd = ((n - 1) / 4 - 1) % 64;
            pd = kd % SW;
            if (pd >= 1 && pd <= DW) exp_dac = tx_m[DW - pd];
        end
        chk("bclk",         32'(bclk),         32'(exp_bclk));
        chk("lrclk",        32'(lrclk),        32'(exp_lr));
        chk("dac_data",     32'(dac_data),     32'(exp_dac));
        chk("sample_valid", 32'(sample_valid), 32'(exp_valid));
        chk("in_sample",    32'(in_sample),    32'(in_m));
        chk("rx_overrun",   32'(rx_overrun),   32'(exp_ovr));
        chk("tx_underrun",  32'(tx_underrun),  32'(exp_und));
        if (sample_valid) valid_seen++;
        if (sample_valid || tx_underrun || rx_overrun)
            $display("txn n=%0d valid=%0b in_sample=%h overrun=%0b underrun=%0b",
                     n, sample_valid, in_sample, rx_overrun, tx_underrun);
        adc_data = 1'($urandom_range(0, 1));
        if (n >= 4 && !reset) begin
            kk = (n / 4 - 1) % 64;
            ff = ((n / 4 - 1) / 64) & 15;
            pd = kk % SW;
            if (pd >= 1 && pd <= DW)
                adc_data = (kk < SW) ? left_w[ff][DW - pd] : right_w[ff][DW - pd];
        end
    endtask

    task automatic run_until(input int target);
        for (int i = 0; i < 20000 && n < target; i++) tick();
    endtask

    task automatic run_random(input int target);
        for (int i = 0; i < 20000 && n < target; i++) begin
            tick();
            if ($urandom_range(0, 99) < 4) out_ready = !out_ready;
            out_sample = 16'($urandom);
        end
    endtask

    initial begin
        for (int f = 0; f < 16; f++) begin
            left_w[f]  = (f < 4) ? 16'hA5C3 : 16'($urandom);
            right_w[f] = (f < 4) ? 16'h1234 : 16'($urandom);
        end
        reset      = 1'b1;
        out_ready  = 1'b1;
        out_sample = '0;
        adc_data   = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b0;

        // Free run through the first left sample.
        run_until(100);
        chk("first_sample", 32'(in_sample), 32'(16'hA5C3));

        // Fresh 8001 captured before frame 1, then ready held high through frame 2.
        out_ready = 1'b0;
        tick();
        out_sample = 16'h8001;
        out_ready  = 1'b1;
        run_until(2 * FRAME_CLK + 10);
        chk("valid_per_frame", 32'(valid_seen), 32'd2);
        run_until(3 * FRAME_CLK + 10);

        // Engine busy when the frame-3 sample arrives.
        out_ready = 1'b0;
        run_until(3 * FRAME_CLK + 100);
        chk("in_sample_overrun", 32'(in_sample), 32'(16'hA5C3));
        out_sample = 16'($urandom);
        out_ready  = 1'b1;
        run_random(4 * FRAME_CLK + 100);

        // Capture edge landing exactly on the frame-5 load edge.
        out_ready = 1'b0;
        run_until(5 * FRAME_CLK + 4);
        out_sample = 16'h5A5A;
        out_ready  = 1'b1;
        run_until(6 * FRAME_CLK + 10);

        run_random(9 * FRAME_CLK + 84);

        // One-cycle reset in bit period 20, then a 7FFF left word.
        left_w[0] = 16'h7FFF;
        left_w[1] = 16'h7FFF;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_until(300);
        chk("in_sample_after_reset", 32'(in_sample), 32'(16'h7FFF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
